// File: rtl/ccd_timing.sv
// ---------------------------------------------------------------------------
// ccd_timing -- linear CCD sequencer
//
// Produces the transfer gate (rog), the two-phase shift clocks (ph1/ph2), the
// output reset gate (rs) and the clamp / CDS-sample pulse (clb) for one frame
// of PX_TOTAL pixels. It also gives the downstream ADC/RAM stage a readout
// window (shoot) and the current pixel index (pxcount).
//
// Frame sequence: IDLE -> ROG -> GUARD -> READ -> IDLE
//   ROG   : one set-up cycle, then rog held high for ROG_CYC cycles
//   GUARD : PHASES cycles with every gate idle before the first pixel
//   READ  : PX_TOTAL pixels, PHASES clk cycles per pixel (phase counter p)
//
// Ports
//   clk        in   system clock (16 MHz); every output is registered on it
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle frame request, honoured only while idle
//   busy       out  high from frame acceptance until frame_done
//   shoot      out  readout window (high throughout READ)
//   pxcount    out  13-bit pixel index; holds PX_TOTAL while idle
//   ph1, ph2   out  complementary CCD shift clocks
//   rog        out  readout (transfer) gate
//   rs         out  CCD output reset gate
//   clb        out  clamp pulse / CDS sample 1
//   frame_done out  one-cycle pulse when the last pixel has been clocked out
//
// Build option
//   CCD_CONT_EN : when defined, the sequencer restarts a frame by itself one
//                 cycle after each frame_done. Only the first frame needs a
//                 start pulse.
// ---------------------------------------------------------------------------
module ccd_timing #(
    parameter int PX_TOTAL = 5474,
    parameter int PHASES   = 16,
    parameter int ROG_CYC  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        shoot,
    output logic [12:0] pxcount,
    output logic        ph1,
    output logic        ph2,
    output logic        rog,
    output logic        rs,
    output logic        clb,
    output logic        frame_done
);

    localparam int CNT_MAX = (ROG_CYC > PHASES) ? ROG_CYC : PHASES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int PW      = (PHASES > 1) ? $clog2(PHASES) : 1;

    localparam logic [12:0]   PX_END    = 13'(PX_TOTAL);
    localparam logic [12:0]   PX_LAST   = 13'(PX_TOTAL - 1);
    localparam logic [CW-1:0] ROG_END   = CW'(ROG_CYC);
    localparam logic [CW-1:0] GUARD_END = CW'(PHASES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [PW-1:0] P_LAST    = PW'(PHASES - 1);
    localparam logic [PW-1:0] P_HALF    = PW'(PHASES / 2);
    localparam logic [PW-1:0] P_ONE     = PW'(1);
    localparam logic [PW-1:0] P_ZERO    = PW'(0);
    localparam logic [PW-1:0] RS_END    = PW'(2);
    localparam logic [PW-1:0] CLB_FIRST = PW'(3);
    localparam logic [PW-1:0] CLB_LAST  = PW'(5);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROG   = 2'd1,
        S_GUARD = 2'd2,
        S_READ  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;        // cycle counter for ROG and GUARD
    logic [PW-1:0] p_q, p_d;            // phase within the current pixel
    logic [12:0]   px_q, px_d;
    logic          busy_q, busy_d;
    logic          shoot_q, shoot_d;
    logic          ph1_q, ph1_d;
    logic          rog_q, rog_d;
    logic          rs_q, rs_d;
    logic          clb_q, clb_d;
    logic          done_q, done_d;

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            p_q     <= P_ZERO;
            px_q    <= PX_END;
            busy_q  <= 1'b0;
            shoot_q <= 1'b0;
            ph1_q   <= 1'b1;
            rog_q   <= 1'b0;
            rs_q    <= 1'b0;
            clb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            px_q    <= px_d;
            busy_q  <= busy_d;
            shoot_q <= shoot_d;
            ph1_q   <= ph1_d;
            rog_q   <= rog_d;
            rs_q    <= rs_d;
            clb_q   <= clb_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and counters
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        px_d    = px_q;
        case (state_q)
            S_IDLE: begin
`ifdef CCD_CONT_EN
                // Free-running: the idle cycle after frame_done replaces the
                // ROG set-up cycle, which keeps the frame period unchanged.
                if (done_q) begin
                    state_d = S_ROG;
                    cnt_d   = CNT_ONE;
                    p_d     = P_ZERO;
                    px_d    = 13'd0;
                end else if (start) begin
                    state_d = S_ROG;
                    cnt_d   = CNT_ZERO;
                    p_d     = P_ZERO;
                    px_d    = 13'd0;
                end else begin
                    state_d = S_IDLE;
                end
`else
                // A start that coincides with frame_done is dropped.
                if (start && !done_q) begin
                    state_d = S_ROG;
                    cnt_d   = CNT_ZERO;
                    p_d     = P_ZERO;
                    px_d    = 13'd0;
                end else begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_ROG: begin
                // cnt 0 is the set-up cycle; rog is high for cnt 1..ROG_CYC
                if (cnt_q == ROG_END) begin
                    state_d = S_GUARD;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_GUARD: begin
                if (cnt_q == GUARD_END) begin
                    state_d = S_READ;
                    cnt_d   = CNT_ZERO;
                    p_d     = P_ZERO;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_READ: begin
                if (p_q == P_LAST) begin
                    p_d  = P_ZERO;
                    px_d = px_q + 13'd1;
                    if (px_q == PX_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    p_d = p_q + P_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
                p_d     = P_ZERO;
                px_d    = PX_END;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with it
    always_comb begin
        busy_d  = (state_d != S_IDLE);
        shoot_d = (state_d == S_READ);
        rog_d   = (state_d == S_ROG) && (cnt_d != CNT_ZERO);
        done_d  = (state_q == S_READ) && (state_d == S_IDLE);
        if (state_d == S_READ) begin
            ph1_d = (p_d < P_HALF);
            rs_d  = (p_d < RS_END);
            clb_d = (p_d >= CLB_FIRST) && (p_d <= CLB_LAST);
        end else begin
            ph1_d = 1'b1;
            rs_d  = 1'b0;
            clb_d = 1'b0;
        end
    end

    assign busy       = busy_q;
    assign shoot      = shoot_q;
    assign pxcount    = px_q;
    assign ph1        = ph1_q;
    assign ph2        = ~ph1_q;
    assign rog        = rog_q;
    assign rs         = rs_q;
    assign clb        = clb_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ccd_timing.sv
module tb_ccd_timing;

    localparam int PX        = 40;
    localparam int PH        = 16;
    localparam int RC        = 64;
    localparam int READ_T    = 1 + RC + PH;          // start edge -> first READ cycle
    localparam int FRAME_LEN = READ_T + PX * PH;     // start edge -> frame_done edge
`ifdef CCD_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, shoot, ph1, ph2, rog, rs, clb, frame_done;
    logic [12:0] pxcount;

    ccd_timing #(.PX_TOTAL(PX), .PHASES(PH), .ROG_CYC(RC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .shoot(shoot),
        .pxcount(pxcount), .ph1(ph1), .ph2(ph2), .rog(rog), .rs(rs), .clb(clb),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: frame described by time since the start edge
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_t      = 0;

    // measurements taken from DUT outputs
    int cyc = 0;
    int rog_hi, shoot_rise, done_cyc, busy_falls, done_count, start_cyc;
    logic busy_prev, shoot_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [20:0] observed();
        return {busy, shoot, pxcount, ph1, ph2, rog, rs, clb, frame_done};
    endfunction

    function automatic logic [20:0] expected();
        logic        e_busy, e_shoot, e_ph1, e_rog, e_rs, e_clb;
        int          px, k, p;
        logic [12:0] e_px;
        e_busy  = m_active;
        e_rog   = m_active && (m_t >= 1) && (m_t <= RC);
        e_shoot = m_active && (m_t >= READ_T);
        k  = m_t - READ_T;
        p  = e_shoot ? (k % PH) : 0;
        px = !m_active ? PX : (e_shoot ? (k / PH) : 0);
        e_px  = 13'(px);
        e_ph1 = e_shoot ? (p < PH / 2) : 1'b1;
        e_rs  = e_shoot && (p < 2);
        e_clb = e_shoot && (p >= 3) && (p <= 5);
        return {e_busy, e_shoot, e_px, e_ph1, ~e_ph1, e_rog, e_rs, e_clb, m_done};
    endfunction

    task automatic clear_meas();
        rog_hi = 0; shoot_rise = 0; done_cyc = 0; busy_falls = 0; done_count = 0;
        start_cyc = 0; busy_prev = busy; shoot_prev = shoot;
    endtask

    // one clock: drive start, advance model on the edge, compare just after
    task automatic tick(input logic st);
        bit prev_done;
        start = st;
        @(posedge clk);
        cyc++;
        prev_done = m_done;
        m_done    = 1'b0;
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_t++;
            if (m_t == FRAME_LEN) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (CONT && prev_done) begin
            m_active = 1'b1;
            m_t      = 1;
        end else if (st && !prev_done) begin
            m_active  = 1'b1;
            m_t       = 0;
            start_cyc = cyc;
        end
        #1;
        check("outputs", 32'(observed()), 32'(expected()));
        if (rog) rog_hi++;
        if (shoot && !shoot_prev) shoot_rise = cyc;
        if (frame_done) begin
            done_count++;
            if (CONT && done_count >= 2) check("done_gap", cyc - done_cyc, FRAME_LEN);
            done_cyc = cyc;
        end
        if (busy_prev && !busy) busy_falls++;
        busy_prev  = busy;
        shoot_prev = shoot;
    endtask

    initial begin
        int s0;
        repeat (3) tick(1'b0);
        #2 rst_n = 1'b1;
        repeat (100) tick(1'b0);
        check("idle_px", pxcount, PX);
        check("idle_ph1", ph1, 1);
        check("idle_busy", busy, 0);
        clear_meas();
`ifdef CCD_CONT_EN
        tick(1'b1);
        s0 = start_cyc;
        for (int i = 0; i < 3 * FRAME_LEN + 5; i++) tick($urandom_range(0, 7) == 0);
        check("first_done", done_cyc - s0 - 2 * FRAME_LEN, FRAME_LEN);
        check("done_count", done_count, 3);
`else
        // single frame with starts during the frame and on frame_done
        tick(1'b1);
        s0 = start_cyc;
        for (int i = 1; i < FRAME_LEN + 5; i++) tick((i == 5) || (i == 500) || m_done);
        check("rog_len", rog_hi, RC);
        check("shoot_rise", shoot_rise - s0, READ_T);
        check("frame_len", done_cyc - s0, FRAME_LEN);
        check("busy_falls", busy_falls, 1);
        check("done_count", done_count, 1);
        check("end_px", pxcount, PX);

        // random start traffic
        for (int i = 0; i < 2 * FRAME_LEN; i++) tick($urandom_range(0, 15) == 0);

        // reset in the middle of pixel 20
        for (int i = 0; i < FRAME_LEN + 2 && (m_active || m_done); i++) tick(1'b0);
        tick(1'b1);
        for (int i = 0; i < FRAME_LEN && m_t < READ_T + 20 * PH; i++) tick(1'b0);
        check("mid_frame_px", pxcount, 20);
        #2 rst_n = 1'b0;
        #1;
        m_active = 1'b0;
        m_done   = 1'b0;
        check("rst_async", 32'(observed()), 32'(expected()));
        clear_meas();
        repeat (2) tick(1'b0);
        #2 rst_n = 1'b1;
        tick(1'b0);
        check("rst_no_done", done_count, 0);
        tick(1'b1);
        s0 = start_cyc;
        for (int i = 0; i < FRAME_LEN + 3; i++) tick(1'b0);
        check("post_rst_len", done_cyc - s0, FRAME_LEN);
        check("post_rst_done", done_count, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccd_timing.md
CCD_TIMING -- requirements
Module: ccd_timing

Interface
REQ-001 Parameter PX_TOTAL, default 5474: number of pixels clocked out per frame.
REQ-002 Parameter PHASES, default 16: clk cycles per pixel; 1 MHz pixel rate at 16 MHz clk.
REQ-003 Parameter ROG_CYC, default 64: clk cycles for which rog is held high during charge transfer.
REQ-004 clk  in  1  system clock, 16 MHz; every output is registered on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle frame request.
REQ-007 busy  out  1  high from frame acceptance until frame_done.
REQ-008 shoot  out  1  readout window to the downstream ADC/RAM stage.
REQ-009 pxcount  out  13  current pixel index, consumed by the ADC stage.
REQ-010 ph1  out  1  CCD shift clock phase 1.
REQ-011 ph2  out  1  CCD shift clock phase 2, complement of ph1.
REQ-012 rog  out  1  readout (transfer) gate.
REQ-013 rs  out  1  CCD output reset gate.
REQ-014 clb  out  1  clamp pulse; the ADC stage also uses it as CDS sample 1.
REQ-015 frame_done  out  1  one-cycle pulse at the end of a frame.

Function
REQ-016 The FSM SHALL have states IDLE, ROG, GUARD and READ.
REQ-017 IDLE: start=1 SHALL move the FSM to ROG on the next edge, set busy=1 and load pxcount=0 on that same edge.
REQ-018 ROG: rog=1, ph1=1, ph2=0 for exactly ROG_CYC cycles, then transition to GUARD.
REQ-019 GUARD: rog=0, ph1=1, rs=0, clb=0 for exactly PHASES cycles, then transition to READ with phase counter p=0.
REQ-020 READ: shoot=1 in every cycle of the state; p counts 0..PHASES-1 and wraps.
REQ-021 READ waveforms, registered and coincident with p: ph1=(p<8); ph2=~ph1; rs=(p==0 or p==1); clb=(3<=p<=5).
REQ-022 At p=PHASES-1, pxcount SHALL increment by 1.
REQ-023 When pxcount reaches PX_TOTAL: transition to IDLE; shoot, busy, rs and clb go 0; ph1=1; frame_done=1 for one cycle.
REQ-024 pxcount SHALL hold PX_TOTAL in IDLE so that downstream writes stay inhibited; it never wraps.
REQ-025 start while busy=1 SHALL be ignored, with no effect on the frame in progress.
REQ-026 start arriving in the same cycle that frame_done is asserted SHALL be ignored; a new frame requires start while busy=0.
REQ-027 Outside READ, rs=0, clb=0 and shoot=0.
REQ-028 Frame length from the start edge to the frame_done edge SHALL be exactly 1 + ROG_CYC + PHASES + PX_TOTAL*PHASES cycles.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, p=0, pxcount=PX_TOTAL, shoot=0, busy=0, frame_done=0, rog=0, rs=0, clb=0, ph1=1, ph2=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done pulse.
REQ-031 Release of rst_n SHALL take effect synchronously to clk; the first start is accepted no earlier than the first edge after release.

Configuration
REQ-032 Macro CCD_CONT_EN defined: in IDLE the FSM SHALL re-enter ROG automatically one cycle after frame_done (free-running frames); start is then ignored.
REQ-033 Macro CCD_CONT_EN undefined: frames SHALL occur only on start, as specified in REQ-017.

Verification
REQ-034 Reset then 100 idle cycles -> pxcount=5474, shoot=0, ph1=1, every other output 0.
REQ-035 Single start pulse -> rog high exactly 64 cycles; shoot rises 81 cycles after the start edge; frame_done 1+64+16+87584 cycles after the start edge; pxcount=5474 afterwards.
REQ-036 Inside READ, sample pixel 10 -> ph1 high 8/low 8; rs at p=0..1; clb at p=3..5; pxcount 10->11 on the edge following p=15.
REQ-037 start pulses at cycles 5 and 500 of a frame, plus start coincident with frame_done -> no restart and no timing change; busy falls once.
REQ-038 rst_n pulled low at pixel 2000 -> all outputs at reset values within the same cycle; no frame_done; a later start yields a full frame.
REQ-039 CCD_CONT_EN defined, single start -> consecutive frame_done pulses spaced exactly 87665 cycles apart, with no further start.
